// File: rtl/bus_avalon_bridge.sv
// Core unified-bus to Avalon-MM master bridge with posted-write FIFO.
// Reads are ordered behind all posted writes via a drain-before-read rule.
module bus_avalon_bridge #(
  parameter int unsigned WB_DEPTH   = 2,
  parameter int unsigned AVL_ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [29:0]           bus_addr,
  input  logic                  bus_start,
  input  logic                  bus_write,
  input  logic [31:0]           bus_data_wr,
  input  logic [3:0]            bus_data_be,
  output logic                  bus_ready,
  output logic [31:0]           bus_data_rd,
  output logic [AVL_ADDR_W-1:0] avl_address,
  output logic                  avl_read,
  output logic                  avl_write,
  output logic [31:0]           avl_writedata,
  output logic [3:0]            avl_byteenable,
  input  logic                  avl_waitrequest,
  input  logic [31:0]           avl_readdata,
  input  logic                  avl_readdatavalid,
  output logic                  wb_empty
);
  localparam int unsigned PW = $clog2(WB_DEPTH);
  localparam int unsigned CW = $clog2(WB_DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WSTALL, S_RDRAIN, S_RCMD, S_RDATA, S_RRESP
  } state_t;

  state_t state, state_n;

  logic [29:0]   fifo_addr [WB_DEPTH];
  logic [31:0]   fifo_data [WB_DEPTH];
  logic [3:0]    fifo_be   [WB_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
  logic [CW-1:0] count, count_n, remain;

  logic [29:0]   req_addr;
  logic [31:0]   req_data;
  logic [3:0]    req_be;

  logic          accept, full, push, pop, capture;
  logic [29:0]   push_addr;
  logic [31:0]   push_data;
  logic [3:0]    push_be;

  logic                  ready_n, read_n, write_n, wb_empty_n;
  logic [AVL_ADDR_W-1:0] address_n;
  logic [31:0]           writedata_n;
  logic [3:0]            byteenable_n;

  assign accept    = bus_start && (state == S_IDLE || state == S_RRESP);
  assign full      = (count == CW'(WB_DEPTH));
  assign pop       = avl_write && !avl_waitrequest;
  assign rd_ptr_nx = rd_ptr + PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Request sequencing; full is the registered count, so a same-cycle pop cannot unblock a stall
  always_comb begin
    state_n   = state;
    push      = 1'b0;
    ready_n   = 1'b0;
    capture   = 1'b0;
    push_addr = bus_addr;
    push_data = bus_data_wr;
    push_be   = bus_data_be;
    case (state)
      S_IDLE, S_RRESP: begin
        state_n = S_IDLE;
        if (bus_start) begin
          if (bus_write) begin
            if (full) begin
              state_n = S_WSTALL;
            end else begin
              push    = 1'b1;
              ready_n = 1'b1;
            end
          end else begin
            state_n = wb_empty ? S_RCMD : S_RDRAIN;
          end
        end
      end
      S_WSTALL: begin
        push_addr = req_addr;
        push_data = req_data;
        push_be   = req_be;
        if (!full) begin
          push    = 1'b1;
          ready_n = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_RDRAIN: if (wb_empty) state_n = S_RCMD;
      S_RCMD:   if (!avl_waitrequest) state_n = S_RDATA;
      S_RDATA: begin
        if (avl_readdatavalid) begin
          capture = 1'b1;
          ready_n = 1'b1;
          state_n = S_RRESP;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Next Avalon command: read command, or the FIFO head (bypassing the push when it becomes head)
  always_comb begin
    count_n      = count + CW'(push) - CW'(pop);
    remain       = count - CW'(pop);
    write_n      = (count_n != '0);
    wb_empty_n   = (count_n == '0) && !write_n;
    read_n       = (state_n == S_RCMD);
    address_n    = avl_address;
    writedata_n  = avl_writedata;
    byteenable_n = avl_byteenable;
    if (state_n == S_RCMD && state != S_RCMD) begin
      address_n    = AVL_ADDR_W'({(state == S_RDRAIN) ? req_addr : bus_addr, 2'b00});
      byteenable_n = 4'hF;
    end else if (push && remain == '0) begin
      address_n    = AVL_ADDR_W'({push_addr, 2'b00});
      writedata_n  = push_data;
      byteenable_n = push_be;
    end else if (pop && remain != '0) begin
      address_n    = AVL_ADDR_W'({fifo_addr[rd_ptr_nx], 2'b00});
      writedata_n  = fifo_data[rd_ptr_nx];
      byteenable_n = fifo_be[rd_ptr_nx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count          <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      req_addr       <= '0;
      req_data       <= '0;
      req_be         <= '0;
      bus_ready      <= 1'b0;
      bus_data_rd    <= '0;
      avl_read       <= 1'b0;
      avl_write      <= 1'b0;
      avl_address    <= '0;
      avl_writedata  <= '0;
      avl_byteenable <= '0;
      wb_empty       <= 1'b1;
    end else begin
      count <= count_n;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr_nx;
      if (accept) begin
        req_addr <= bus_addr;
        req_data <= bus_data_wr;
        req_be   <= bus_data_be;
      end
      bus_ready <= ready_n;
      if (capture) bus_data_rd <= avl_readdata;
      avl_read       <= read_n;
      avl_write      <= write_n;
      avl_address    <= address_n;
      avl_writedata  <= writedata_n;
      avl_byteenable <= byteenable_n;
      wb_empty       <= wb_empty_n;
    end
  end

  // FIFO storage needs no reset: occupancy is tracked by count/pointers
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= push_addr;
      fifo_data[wr_ptr] <= push_data;
      fifo_be[wr_ptr]   <= push_be;
    end
  end

endmodule
